// File: rtl/btb_update_controller_if.sv
// btb_update_controller_if: EX resolve inputs, BTB write port and pipeline control signals
interface btb_update_controller_if #(parameter int INDEX_BITS = 4);
   logic                       EX_Valid;
   logic                       EX_Is_Branch;
   logic [31:0]                EX_PC_4;
   logic                       EX_Taken;
   logic [31:0]                EX_Target;
   logic                       EX_Pred_Taken;
   logic [31:0]                EX_Pred_Target;
   logic                       BTB_Write_Grant;
   logic                       BTB_WE;
   logic [INDEX_BITS-1:0]      BTB_Index;
   logic [32-INDEX_BITS-3:0]   BTB_Tag;
   logic [31:0]                BTB_Target;
   logic                       BTB_Valid;
   logic [1:0]                 BTB_Counter;
   logic                       Mispredict;
   logic [31:0]                Redirect_PC;
   logic                       Stall_EX;
   logic                       Init_Busy;
   modport slave (
      input  EX_Valid, EX_Is_Branch, EX_PC_4, EX_Taken, EX_Target, EX_Pred_Taken, EX_Pred_Target,
             BTB_Write_Grant,
      output BTB_WE, BTB_Index, BTB_Tag, BTB_Target, BTB_Valid, BTB_Counter,
             Mispredict, Redirect_PC, Stall_EX, Init_Busy
   );
   modport master (
      output EX_Valid, EX_Is_Branch, EX_PC_4, EX_Taken, EX_Target, EX_Pred_Taken, EX_Pred_Target,
             BTB_Write_Grant,
      input  BTB_WE, BTB_Index, BTB_Tag, BTB_Target, BTB_Valid, BTB_Counter,
             Mispredict, Redirect_PC, Stall_EX, Init_Busy
   );
endinterface

// File: rtl/btb_update_controller.sv
// btb_update_controller: BTB init sweep, 2-bit direction counters, mispredict detection and queued BTB writes
module btb_update_controller #(
   parameter int INDEX_BITS = 4,
   parameter int QDEPTH     = 4
) (
   input logic CLK,
   input logic RESET,
   btb_update_controller_if.slave bus
);
   localparam int ENTRIES = 2**INDEX_BITS;
   localparam int TW      = 30 - INDEX_BITS;
   localparam int EW      = INDEX_BITS + TW + 35;
   localparam int PW      = $clog2(QDEPTH);
   localparam int CW      = $clog2(QDEPTH + 1);
   typedef enum logic {INIT, RUN} state_t;
   state_t                r_state, w_next;
   logic [INDEX_BITS-1:0] r_sweep;
   logic [1:0]            r_cnt [ENTRIES];
   logic [EW-1:0]         r_q [QDEPTH];
   logic [PW-1:0]         r_rd, r_wr;
   logic [CW-1:0]         r_count;
   logic                  r_mis;
   logic [31:0]           r_redir;
   logic [31:0]           w_pc;
   logic [INDEX_BITS-1:0] w_idx;
   logic [TW-1:0]         w_tag;
   logic [1:0]            w_c, w_cn;
   logic                  w_full, w_res, w_tmis, w_mis, w_enq, w_deq;
   assign w_pc   = bus.EX_PC_4 - 32'd4;
   assign w_idx  = w_pc[INDEX_BITS+1:2];
   assign w_tag  = w_pc[31:INDEX_BITS+2];
   assign w_c    = r_cnt[w_idx];
   assign w_cn   = bus.EX_Taken ? ((w_c == 2'd3) ? 2'd3 : w_c + 2'd1) : ((w_c == 2'd0) ? 2'd0 : w_c - 2'd1);
   assign w_full = r_count == CW'(QDEPTH);
   assign w_tmis = bus.EX_Taken & (bus.EX_Target != bus.EX_Pred_Target);
   assign w_mis  = (bus.EX_Pred_Taken != bus.EX_Taken) | w_tmis;
   assign w_res  = !RESET & (r_state == RUN) & bus.EX_Valid & bus.EX_Is_Branch & !bus.Stall_EX;
   // Stall guarantees a full FIFO is only written when the head pops in the same cycle
   assign w_enq  = w_res & ((w_cn != w_c) | w_tmis);
   always_comb begin
      w_next          = r_state;
      w_deq           = 1'b0;
      bus.BTB_WE      = 1'b0;
      bus.BTB_Index   = '0;
      bus.BTB_Tag     = '0;
      bus.BTB_Target  = '0;
      bus.BTB_Valid   = 1'b0;
      bus.BTB_Counter = '0;
      bus.Stall_EX    = 1'b0;
      bus.Mispredict  = RESET ? 1'b0 : r_mis;
      bus.Redirect_PC = RESET ? 32'd0 : r_redir;
      bus.Init_Busy   = RESET | (r_state == INIT);
      if (RESET) begin
         w_next = INIT;
      end else if (r_state == INIT) begin
         bus.Stall_EX    = 1'b1;
         bus.BTB_WE      = bus.BTB_Write_Grant;
         bus.BTB_Index   = r_sweep;
         bus.BTB_Counter = 2'b01;
         w_next          = (bus.BTB_Write_Grant && &r_sweep) ? RUN : INIT;
      end else begin
         w_deq        = (r_count != '0) & bus.BTB_Write_Grant;
         bus.Stall_EX = w_full & !bus.BTB_Write_Grant;
         bus.BTB_WE   = w_deq;
         {bus.BTB_Index, bus.BTB_Tag, bus.BTB_Target, bus.BTB_Valid, bus.BTB_Counter} = r_q[r_rd];
      end
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= INIT;
         r_sweep <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_mis   <= 1'b0;
         r_redir <= '0;
         for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= 2'b01;
      end else begin
         r_state <= w_next;
         r_mis   <= w_res & w_mis;
         r_count <= r_count + CW'(w_enq) - CW'(w_deq);
         if (r_state == INIT && bus.BTB_Write_Grant) r_sweep <= r_sweep + 1'b1;
         if (w_res && w_mis) r_redir <= bus.EX_Taken ? bus.EX_Target : bus.EX_PC_4;
         if (w_res) r_cnt[w_idx] <= w_cn;
         if (w_enq) begin
            r_q[r_wr] <= {w_idx, w_tag, bus.EX_Target, w_cn[1], w_cn};
            r_wr      <= r_wr + 1'b1;
         end
         if (w_deq) r_rd <= r_rd + 1'b1;
      end
   end
endmodule

// File: tb/tb_btb_update_controller.sv
// tb_btb_update_controller: directed checks of init sweep, counters, mispredicts, FIFO stall/drain and reset
module tb_btb_update_controller;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   writes, cycles;
   always #5 clk = ~clk;
   btb_update_controller_if #(.INDEX_BITS(4)) bus ();
   btb_update_controller #(.INDEX_BITS(4), .QDEPTH(4)) dut (.CLK(clk), .RESET(rst), .bus(bus));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic present(input logic [31:0] pc4, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
      bus.EX_Valid       = 1'b1;
      bus.EX_Is_Branch   = 1'b1;
      bus.EX_PC_4        = pc4;
      bus.EX_Taken       = tk;
      bus.EX_Target      = tgt;
      bus.EX_Pred_Taken  = ptk;
      bus.EX_Pred_Target = ptgt;
   endtask
   task automatic idle();
      bus.EX_Valid = 1'b0;
   endtask
   task automatic reset_cycle();
      rst = 1'b1;
      #1;
      chk("rst_we", bus.BTB_WE, 0);
      chk("rst_busy", bus.Init_Busy, 1);
      chk("rst_stall", bus.Stall_EX, 0);
      chk("rst_mis", bus.Mispredict, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic full_sweep();
      bus.BTB_Write_Grant = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("sw_we", bus.BTB_WE, 1);
         chk("sw_idx", bus.BTB_Index, i);
         chk("sw_valid", bus.BTB_Valid, 0);
         @(negedge clk);
      end
      #1;
      chk("sw_busy_fall", bus.Init_Busy, 0);
      chk("sw_we_after", bus.BTB_WE, 0);
   endtask
   initial begin
      rst = 1'b1;
      bus.BTB_Write_Grant = 1'b1;
      bus.EX_Is_Branch = 1'b0;
      bus.EX_PC_4 = '0;
      bus.EX_Taken = 1'b0;
      bus.EX_Target = '0;
      bus.EX_Pred_Taken = 1'b0;
      bus.EX_Pred_Target = '0;
      idle();
      reset_cycle();
      full_sweep();
      // sweep with grant low for three cycles in the middle
      @(negedge clk);
      reset_cycle();
      writes = 0;
      cycles = 0;
      for (int c = 0; c < 40; c++) begin
         bus.BTB_Write_Grant = !(c >= 5 && c < 8);
         #1;
         if (!bus.Init_Busy) break;
         cycles++;
         if (bus.BTB_WE) begin
            chk("pause_idx", bus.BTB_Index, writes);
            writes++;
         end
         @(negedge clk);
      end
      chk("pause_writes", writes, 16);
      chk("pause_cycles", cycles, 19);
      bus.BTB_Write_Grant = 1'b1;
      @(negedge clk);
      // taken branch predicted not-taken at index 15
      present(32'h40, 1, 32'h10, 0, 32'h0);
      #1;
      chk("t2_stall", bus.Stall_EX, 0);
      chk("t2_we0", bus.BTB_WE, 0);
      @(negedge clk);
      idle();
      #1;
      chk("t2_mis", bus.Mispredict, 1);
      chk("t2_redir", bus.Redirect_PC, 32'h10);
      chk("t2_we", bus.BTB_WE, 1);
      chk("t2_idx", bus.BTB_Index, 15);
      chk("t2_tag", bus.BTB_Tag, 0);
      chk("t2_cnt", bus.BTB_Counter, 2'b10);
      chk("t2_valid", bus.BTB_Valid, 1);
      chk("t2_tgt", bus.BTB_Target, 32'h10);
      @(negedge clk);
      #1;
      chk("t2_mis_pulse", bus.Mispredict, 0);
      chk("t2_we_once", bus.BTB_WE, 0);
      // three correctly predicted taken resolves: 10 -> 11, then saturated with no writes
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         present(32'h40, 1, 32'h10, 1, 32'h10);
         @(negedge clk);
         idle();
         #1;
         chk("t3_mis", bus.Mispredict, 0);
         chk("t3_we", bus.BTB_WE, k == 0);
         if (k == 0) chk("t3_cnt", bus.BTB_Counter, 2'b11);
      end
      // fill FIFO with grant low, fifth branch stalls, then drain
      @(negedge clk);
      bus.BTB_Write_Grant = 1'b0;
      for (int k = 0; k < 4; k++) begin
         present(32'h1004 + 4 * k, 1, 32'h2000 + 16 * k, 0, 32'h0);
         #1;
         chk("t4_nostall", bus.Stall_EX, 0);
         @(negedge clk);
      end
      present(32'h1014, 1, 32'h2040, 0, 32'h0);
      #1;
      chk("t4_stall", bus.Stall_EX, 1);
      chk("t4_we_low", bus.BTB_WE, 0);
      chk("t4_mis_k3", bus.Redirect_PC, 32'h2030);
      @(negedge clk);
      bus.BTB_Write_Grant = 1'b1;
      #1;
      chk("t4_stall_rel", bus.Stall_EX, 0);
      chk("t4_no_mis", bus.Mispredict, 0);
      chk("t4_we0", bus.BTB_WE, 1);
      chk("t4_idx0", bus.BTB_Index, 0);
      chk("t4_tgt0", bus.BTB_Target, 32'h2000);
      @(negedge clk);
      idle();
      #1;
      chk("t4_mis5", bus.Mispredict, 1);
      chk("t4_redir5", bus.Redirect_PC, 32'h2040);
      for (int k = 1; k < 5; k++) begin
         #1;
         chk("t4_drain_we", bus.BTB_WE, 1);
         chk("t4_drain_idx", bus.BTB_Index, k);
         chk("t4_drain_tag", bus.BTB_Tag, 26'h40);
         chk("t4_drain_tgt", bus.BTB_Target, 32'h2000 + 16 * k);
         @(negedge clk);
      end
      #1;
      chk("t4_empty", bus.BTB_WE, 0);
      // not-taken, predicted not-taken at counter 01: write counter 00 with valid 0
      present(32'h1024, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      idle();
      #1;
      chk("t5_mis", bus.Mispredict, 0);
      chk("t5_we", bus.BTB_WE, 1);
      chk("t5_idx", bus.BTB_Index, 8);
      chk("t5_cnt", bus.BTB_Counter, 2'b00);
      chk("t5_valid", bus.BTB_Valid, 0);
      @(negedge clk);
      // two pending entries, then reset; later reset mid-sweep at index 7
      bus.BTB_Write_Grant = 1'b0;
      present(32'h1018, 1, 32'h3000, 0, 32'h0);
      @(negedge clk);
      present(32'h101C, 1, 32'h3010, 0, 32'h0);
      @(negedge clk);
      idle();
      reset_cycle();
      bus.BTB_Write_Grant = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("t6_idx", bus.BTB_Index, i);
         @(negedge clk);
      end
      #1;
      chk("t6_idx7", bus.BTB_Index, 7);
      reset_cycle();
      full_sweep();
      chk("t6_no_queued", bus.BTB_WE, 0);
      present(32'h1004, 1, 32'h2000, 1, 32'h2000);
      @(negedge clk);
      idle();
      #1;
      chk("t6_we", bus.BTB_WE, 1);
      chk("t6_cnt_reset", bus.BTB_Counter, 2'b10);
      chk("t6_mis", bus.Mispredict, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
